seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter: W, default 8, operand width in bits; result width is 2*W.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: ld  input  1  start request from the colour generator, sampled as a level.
REQ-005 Port: mult1  input  W  multiplicand, valid whenever ld=1.
REQ-006 Port: mult2  input  W  multiplier, valid whenever ld=1.
REQ-007 Port: mult_res  output  2*W  unsigned product mult1*mult2, registered.
REQ-008 Port: mult_ok  output  1  done strobe, high for exactly one cycle per operation.
REQ-009 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, RUN, DONE and REARM.
REQ-011 IDLE with ld=1: capture mult1 into the multiplicand register (zero-extended to 2*W), capture mult2 into the shift register, clear the accumulator and step counter, go to RUN.
REQ-012 IDLE with ld=0: remain in IDLE; all registers hold.
REQ-013 RUN: each cycle, if the shift-register LSB is 1, add the multiplicand to the accumulator (2*W wide, no overflow possible); then shift the multiplicand left 1, shift the shift register right 1, and increment the counter.
REQ-014 RUN: after the W-th step, load the final accumulator into mult_res, set mult_ok=1 and go to DONE.
REQ-015 Latency: with capture at edge E0, mult_ok is high in the cycle following edge E0+W (W=8: 8 cycles after capture); this latency is fixed and independent of operand values.
REQ-016 DONE: lasts one cycle; mult_ok is cleared on exit; the next state is REARM.
REQ-017 REARM: remain while ld=1; go to IDLE on ld=0; a new operation is never started from REARM.
REQ-018 mult_res SHALL hold its value from mult_ok assertion until the next REQ-014 load, including through IDLE and REARM.
REQ-019 ld and operand changes during RUN, DONE or REARM SHALL be ignored; operands are sampled only at REQ-011.
REQ-020 Handshake compatibility: the consumer asserts ld while mult_ok=0, holds it until it samples mult_ok=1, then drops it. The minimum spacing from mult_ok to the next capture is 3 edges (DONE->REARM, REARM->IDLE, IDLE capture). The one-cycle strobe guarantees the consumer never sees a stale mult_ok=1 in its next state.
REQ-021 busy: 1 in RUN, DONE and REARM; 0 in IDLE.

Reset
REQ-022 reset=1 at an edge: state becomes IDLE; mult_res=0, mult_ok=0 and busy=0; accumulator, shift registers and counter are all cleared.
REQ-023 Reset SHALL take priority over every transition, including mid-RUN (aborts with no mult_ok pulse) and in DONE (pulse is truncated).
REQ-024 First cycle after reset deasserts: if ld=1, capture per REQ-011.

Verification
REQ-025 ld=1, mult1=0xFF, mult2=0xFF -> mult_res=0xFE01 with a single mult_ok pulse 8 cycles after capture.
REQ-026 Operand pairs (0x00,0xC8), (0x01,0xC8) and (0x80,0x02) -> 0x0000, 0x00C8 and 0x0100; latency identical in all cases.
REQ-027 ld held high for 20 cycles after mult_ok -> exactly one mult_ok pulse, FSM stays in REARM, mult_res stable; ld low then high -> new operation with operands sampled at the re-capture.
REQ-028 Consumer-model bench performs four back-to-back products (lint=0x80 times 0xFF, 0x40, 0x00 and 0x10) -> 0x7F80, 0x2000, 0x0000 and 0x0800 in order, each captured exactly once.
REQ-029 reset=1 on the 4th RUN cycle of 0xFF*0xFF -> next cycle mult_res=0, mult_ok=0 and busy=0, with no pulse; a following op 0x03*0x05 -> 0x000F.
REQ-030 mult1/mult2 toggled randomly during RUN -> result equals the product of the operands present at capture.

Source files
------------

// File: rtl/seq_mult_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_if
// Purpose  : Start/result handshake bundle between a requester and seq_mult.
// Revision : 1.0
// ============================================================================
interface seq_mult_if #(
    parameter int W = 8
);
    logic           ld;
    logic [W-1:0]   mult1;
    logic [W-1:0]   mult2;
    logic [2*W-1:0] mult_res;
    logic           mult_ok;
    logic           busy;

    modport master (
        output ld,
        output mult1,
        output mult2,
        input  mult_res,
        input  mult_ok,
        input  busy
    );

    modport slave (
        input  ld,
        input  mult1,
        input  mult2,
        output mult_res,
        output mult_ok,
        output busy
    );
endinterface : seq_mult_if
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult
// Purpose  : Unsigned shift-and-add multiplier, one partial product per cycle,
//            with a one-cycle done strobe and a rearm state for level requests.
// Revision : 1.0
// ============================================================================
module seq_mult #(
    parameter int W = 8
) (
    input  wire logic clk,
    input  wire logic reset,
    seq_mult_if.slave bus
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] c_last_step = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        REARM = 2'd3
    } state_t;

    state_t         r_state;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] r_res;
    logic           r_ok;
    logic           r_busy;

    logic [2*W-1:0] w_acc_next;

    // The accumulator can never overflow: the sum of all partial products is
    // bounded by (2^W-1)^2 < 2^(2W).
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_ok     <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ld) begin
                        r_mcand  <= {{W{1'b0}}, bus.mult1};
                        r_mplier <= bus.mult2;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == c_last_step) begin
                        r_res   <= w_acc_next;
                        r_ok    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_ok    <= 1'b0;
                    r_state <= REARM;
                end
                REARM: begin
                    // A held request must be released before another capture.
                    if (!bus.ld) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ok    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mult_res = r_res;
    assign bus.mult_ok  = r_ok;
    assign bus.busy     = r_busy;

endmodule : seq_mult
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult
// Purpose  : Directed self-checking bench for seq_mult (W = 8).
// Revision : 1.0
// ============================================================================
module tb_seq_mult;

    localparam int W = 8;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    seq_mult_if #(.W(W)) bus ();

    seq_mult #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer model: request, scramble operands while running, wait for the
    // strobe, optionally keep ld held, then release and wait for IDLE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input int hold);
        int   n;
        int   extra_ok;
        logic seen;
        @(posedge clk); #1;
        bus.ld = 1'b1; bus.mult1 = a; bus.mult2 = b;
        @(posedge clk); #1;
        check({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
        seen = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            bus.mult1 = 8'($urandom); bus.mult2 = 8'($urandom);
            @(posedge clk); #1;
            n++;
            if (bus.mult_ok) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_ok_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_result"}, 32'(bus.mult_res), 32'(exp));
        extra_ok = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.mult_ok) extra_ok++;
        end
        if (hold > 0) begin
            check({tag, "_hold_no_extra_ok"}, 32'(extra_ok), 32'd0);
            check({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
            check({tag, "_hold_result"}, 32'(bus.mult_res), 32'(exp));
        end
        bus.ld = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ok_one_cycle"}, 32'(bus.mult_ok), 32'd0);
        n = 0;
        while (bus.busy && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        check({tag, "_result_held"}, 32'(bus.mult_res), 32'(exp));
    endtask

    initial begin
        int n_ok;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.ld    = 1'b0;
        bus.mult1 = '0;
        bus.mult2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", 32'(bus.mult_res), 32'd0);
        check("rst_ok", 32'(bus.mult_ok), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        run_op("ff_ff", 8'hFF, 8'hFF, 16'hFE01, 0);
        run_op("00_c8", 8'h00, 8'hC8, 16'h0000, 0);
        run_op("01_c8", 8'h01, 8'hC8, 16'h00C8, 0);
        run_op("80_02", 8'h80, 8'h02, 16'h0100, 0);

        run_op("hold20", 8'h0D, 8'h0B, 16'h008F, 20);
        run_op("recap", 8'h21, 8'h03, 16'h0063, 0);

        run_op("b2b_ff", 8'h80, 8'hFF, 16'h7F80, 0);
        run_op("b2b_40", 8'h80, 8'h40, 16'h2000, 0);
        run_op("b2b_00", 8'h80, 8'h00, 16'h0000, 0);
        run_op("b2b_10", 8'h80, 8'h10, 16'h0800, 0);

        run_op("pre_rst", 8'h07, 8'h09, 16'h003F, 0);
        // Reset lands on the 4th RUN edge of 0xFF*0xFF.
        @(posedge clk); #1;
        bus.ld = 1'b1; bus.mult1 = 8'hFF; bus.mult2 = 8'hFF;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        bus.ld = 1'b0;
        check("midrun_rst_res", 32'(bus.mult_res), 32'd0);
        check("midrun_rst_ok", 32'(bus.mult_ok), 32'd0);
        check("midrun_rst_busy", 32'(bus.busy), 32'd0);
        n_ok = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.mult_ok) n_ok++;
        end
        check("midrun_rst_no_pulse", 32'(n_ok), 32'd0);
        run_op("post_rst", 8'h03, 8'h05, 16'h000F, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_mult
`default_nettype wire
